// File: rtl/rob_pr_free_q_if.sv
// Free-list return interface for rob_pr_free_q.
// Groups the ROB commit enqueue handshake and the per-bank free-list return
// handshake. The queue itself connects through the slave modport; the
// environment (ROB commit stage plus free_list banks) uses the master modport.
interface rob_pr_free_q_if #(
    parameter int LANES      = 4,
    parameter int PR_WIDTH   = 7,
    parameter int BANK_COUNT = 4,
    parameter int UPPER_W    = PR_WIDTH - $clog2(BANK_COUNT)
);
    logic                          enq_valid;
    logic [LANES-1:0]              enq_lane_valid_by_lane;
    logic [LANES*PR_WIDTH-1:0]     enq_PR_by_lane;
    logic                          enq_ready;
    logic [BANK_COUNT-1:0]         free_valid_by_bank;
    logic [BANK_COUNT*UPPER_W-1:0] free_upper_PR_by_bank;
    logic [BANK_COUNT-1:0]         free_ready_by_bank;
    logic                          empty;

    modport master (
        output enq_valid, enq_lane_valid_by_lane, enq_PR_by_lane, free_ready_by_bank,
        input  enq_ready, free_valid_by_bank, free_upper_PR_by_bank, empty
    );

    modport slave (
        input  enq_valid, enq_lane_valid_by_lane, enq_PR_by_lane, free_ready_by_bank,
        output enq_ready, free_valid_by_bank, free_upper_PR_by_bank, empty
    );
endinterface

// File: rtl/rob_pr_free_q.sv
// rob_pr_free_q: buffers physical registers freed at ROB commit and returns
// them, one per bank per cycle, to the banked free list. Bundles drain in
// order; only the head slot is serviced, and same-bank lanes inside a bundle
// are serialized lowest lane first.
//
// Optional build macro ROB_PR_FREE_Q_ZERO_FILTER_EN: when defined, lanes
// carrying PR 0 are dropped at enqueue (p0 is reserved for x0 and never
// returns to the free list). When undefined, PR 0 is an ordinary PR.
module rob_pr_free_q #(
    parameter int ENTRIES    = 2,
    parameter int LANES      = 4,
    parameter int BANK_COUNT = 4,
    parameter int PR_WIDTH   = 7
) (
    input  logic            CLK,
    input  logic            RST,
    rob_pr_free_q_if.slave  bus
);
    localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int PTR_W   = IDX_W + 1;
    localparam int BANK_W  = $clog2(BANK_COUNT);
    localparam int UPPER_W = PR_WIDTH - BANK_W;
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;

    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [LANES-1:0]    slot_pend [ENTRIES];
    logic [PR_WIDTH-1:0] slot_pr   [ENTRIES][LANES];

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             full;
    logic             is_empty;
    logic [LANES-1:0] enq_mask;
    logic [LANES-1:0] head_pend;
    logic [LANES-1:0] accepted;
    logic             enq_fire;
    logic             deq_fire;

    logic [BANK_COUNT-1:0]             sel_valid;
    logic [BANK_COUNT-1:0][LANE_W-1:0] sel_lane;
    logic [BANK_COUNT*UPPER_W-1:0]     sel_upper;

    // Advance a pointer modulo ENTRIES, toggling the wrap bit on rollover.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p[IDX_W-1:0] == IDX_W'(ENTRIES - 1))
            return {~p[PTR_W-1], {IDX_W{1'b0}}};
        return p + 1'b1;
    endfunction

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];
    assign is_empty = (head == tail);
    assign full     = (head_idx == tail_idx) && (head[PTR_W-1] != tail[PTR_W-1]);

    // Effective lane mask of the offered bundle.
`ifdef ROB_PR_FREE_Q_ZERO_FILTER_EN
    always_comb begin
        enq_mask = '0;
        for (int l = 0; l < LANES; l++)
            enq_mask[l] = bus.enq_lane_valid_by_lane[l] &&
                          (bus.enq_PR_by_lane[l*PR_WIDTH +: PR_WIDTH] != '0);
    end
`else
    assign enq_mask = bus.enq_lane_valid_by_lane;
`endif

    // An all-invalid bundle is dropped without consuming a slot.
    assign enq_fire  = bus.enq_valid && !full && (enq_mask != '0);
    assign head_pend = is_empty ? '0 : slot_pend[head_idx];

    // Per bank, pick the lowest pending head lane that maps to that bank.
    always_comb begin
        sel_valid = '0;
        sel_lane  = '0;
        sel_upper = '0;
        accepted  = '0;
        for (int b = 0; b < BANK_COUNT; b++) begin
            for (int l = LANES - 1; l >= 0; l--) begin
                if (head_pend[l] && (slot_pr[head_idx][l][BANK_W-1:0] == BANK_W'(b))) begin
                    sel_valid[b] = 1'b1;
                    sel_lane[b]  = LANE_W'(l);
                end
            end
            if (sel_valid[b]) begin
                sel_upper[b*UPPER_W +: UPPER_W] = slot_pr[head_idx][sel_lane[b]][PR_WIDTH-1:BANK_W];
                if (bus.free_ready_by_bank[b])
                    accepted[sel_lane[b]] = 1'b1;
            end
        end
    end

    // Head retires once every pending lane is either gone or accepted now.
    assign deq_fire = !is_empty && ((head_pend & ~accepted) == '0);

    // Pointers and pending masks; reset discards everything in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            head <= '0;
            tail <= '0;
            for (int e = 0; e < ENTRIES; e++)
                slot_pend[e] <= '0;
        end else begin
            if (!is_empty)
                slot_pend[head_idx] <= head_pend & ~accepted;
            if (enq_fire) begin
                slot_pend[tail_idx] <= enq_mask;
                tail                <= ptr_inc(tail);
            end
            if (deq_fire)
                head <= ptr_inc(head);
        end
    end

    // PR payload storage; only meaningful where the pending mask is set.
    always_ff @(posedge CLK) begin
        if (enq_fire)
            for (int l = 0; l < LANES; l++)
                slot_pr[tail_idx][l] <= bus.enq_PR_by_lane[l*PR_WIDTH +: PR_WIDTH];
    end

    assign bus.enq_ready             = !full;
    assign bus.empty                 = is_empty;
    assign bus.free_valid_by_bank    = sel_valid;
    assign bus.free_upper_PR_by_bank = sel_upper;
endmodule

// File: tb/tb_rob_pr_free_q.sv
// Self-checking bench for rob_pr_free_q: directed scenarios plus random
// traffic, with a queue-of-bundles reference model checked every cycle.
module tb_rob_pr_free_q;
    localparam int ENTRIES = 2;
    localparam int MQ      = 256;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;
    bit   chk_en;

    rob_pr_free_q_if bus ();

    rob_pr_free_q dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: ring of bundles, each a PR list plus remaining-lane mask.
    logic [6:0] m_pr   [MQ][4];
    logic [3:0] m_mask [MQ];
    int         m_head;
    int         m_tail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic enq(input logic [3:0] mask, input logic [27:0] prs);
        bus.enq_valid              = 1'b1;
        bus.enq_lane_valid_by_lane = mask;
        bus.enq_PR_by_lane         = prs;
    endtask

    task automatic idle();
        bus.enq_valid              = 1'b0;
        bus.enq_lane_valid_by_lane = '0;
    endtask

    // Monitor: compare DUT outputs to the model, then advance the model by
    // the handshakes and the enqueue the coming clock edge will perform.
    always @(negedge CLK) begin
        if (chk_en) begin
            int         hi;
            int         ti;
            int         el [4];
            logic [3:0] ev;
            logic [19:0] eu;
            logic       erdy;
            logic [3:0] em;
            hi = m_head % MQ;
            ev = '0;
            eu = '0;
            for (int b = 0; b < 4; b++) el[b] = 0;
            if (m_head != m_tail) begin
                for (int b = 0; b < 4; b++)
                    for (int l = 0; l < 4; l++)
                        if (!ev[b] && m_mask[hi][l] && (m_pr[hi][l] % 4 == b)) begin
                            ev[b]          = 1'b1;
                            eu[b*5 +: 5]   = 5'(m_pr[hi][l] / 4);
                            el[b]          = l;
                        end
            end
            erdy = (m_tail - m_head) < ENTRIES;
            chk("mon_free_valid", 32'(bus.free_valid_by_bank), 32'(ev));
            chk("mon_free_upper", 32'(bus.free_upper_PR_by_bank), 32'(eu));
            chk("mon_enq_ready", 32'(bus.enq_ready), 32'(erdy));
            chk("mon_empty", 32'(bus.empty), 32'(m_head == m_tail));
            if (RST) begin
                m_head = m_tail;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (ev[b] && bus.free_ready_by_bank[b])
                        m_mask[hi][el[b]] = 1'b0;
                if (m_head != m_tail && m_mask[hi] == 4'd0)
                    m_head++;
                if (bus.enq_valid && erdy) begin
                    em = bus.enq_lane_valid_by_lane;
`ifdef ROB_PR_FREE_Q_ZERO_FILTER_EN
                    for (int l = 0; l < 4; l++)
                        if (bus.enq_PR_by_lane[l*7 +: 7] == 7'd0) em[l] = 1'b0;
`endif
                    if (em != 4'd0) begin
                        ti         = m_tail % MQ;
                        m_mask[ti] = em;
                        for (int l = 0; l < 4; l++)
                            m_pr[ti][l] = bus.enq_PR_by_lane[l*7 +: 7];
                        m_tail++;
                    end
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        m_head = 0;
        m_tail = 0;
        RST    = 1'b1;
        bus.enq_valid              = 1'b0;
        bus.enq_lane_valid_by_lane = '0;
        bus.enq_PR_by_lane         = '0;
        bus.free_ready_by_bank     = '0;
        cyc();
        chk_en = 1'b1;
        cyc();
        RST = 1'b0;

        // reset state
        chk("rst_enq_ready", 32'(bus.enq_ready), 32'd1);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_free_valid", 32'(bus.free_valid_by_bank), 32'd0);
        chk("rst_free_upper", 32'(bus.free_upper_PR_by_bank), 32'd0);

        // distinct banks, all ready
        bus.free_ready_by_bank = 4'hF;
        enq(4'hF, {7'h0F, 7'h0A, 7'h05, 7'h10});
        cyc();
        idle();
        chk("distinct_valid", 32'(bus.free_valid_by_bank), 32'hF);
        chk("distinct_upper", 32'(bus.free_upper_PR_by_bank), 32'({5'd3, 5'd2, 5'd1, 5'd4}));
        cyc();
        chk("distinct_empty", 32'(bus.empty), 32'd1);

        // same-bank conflict serializes on bank 1
        enq(4'hF, {7'h11, 7'h0D, 7'h09, 7'h05});
        cyc();
        idle();
        for (int k = 1; k <= 4; k++) begin
            chk("conflict_valid", 32'(bus.free_valid_by_bank), 32'h2);
            chk("conflict_upper", 32'(bus.free_upper_PR_by_bank[9:5]), 32'(k));
            cyc();
        end
        chk("conflict_empty", 32'(bus.empty), 32'd1);

        // backpressure on banks 1 and 3
        bus.free_ready_by_bank = 4'b0101;
        enq(4'hF, {7'h0F, 7'h0A, 7'h05, 7'h10});
        cyc();
        idle();
        chk("bp_first_valid", 32'(bus.free_valid_by_bank), 32'hF);
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("bp_hold_valid", 32'(bus.free_valid_by_bank), 32'b1010);
            chk("bp_hold_upper", 32'(bus.free_upper_PR_by_bank), 32'({5'd3, 5'd0, 5'd1, 5'd0}));
        end
        bus.free_ready_by_bank = 4'hF;
        cyc();
        chk("bp_empty", 32'(bus.empty), 32'd1);

        // full queue ignores a third bundle until a slot frees
        bus.free_ready_by_bank = 4'h0;
        enq(4'b0001, {7'h00, 7'h00, 7'h00, 7'h04});
        cyc();
        enq(4'b0010, {7'h00, 7'h00, 7'h21, 7'h00});
        cyc();
        enq(4'b0100, {7'h00, 7'h32, 7'h00, 7'h00});
        chk("full_enq_ready", 32'(bus.enq_ready), 32'd0);
        cyc();
        chk("full_still", 32'(bus.enq_ready), 32'd0);
        bus.free_ready_by_bank = 4'hF;
        cyc();
        chk("full_after_deq", 32'(bus.enq_ready), 32'd1);
        cyc();
        idle();
        repeat (3) cyc();
        chk("full_drained", 32'(bus.empty), 32'd1);

        // empty mask dropped, then pointers wrap over several bundles
        enq(4'b0000, {7'h11, 7'h22, 7'h33, 7'h44});
        cyc();
        idle();
        chk("nomask_empty", 32'(bus.empty), 32'd1);
        for (int i = 0; i < 5; i++) begin
            enq(4'(($urandom % 15) + 1), 28'($urandom));
            bus.free_ready_by_bank = 4'($urandom);
            cyc();
            idle();
            repeat (4) begin
                bus.free_ready_by_bank = 4'($urandom);
                cyc();
            end
        end
        bus.free_ready_by_bank = 4'hF;
        repeat (6) cyc();
        chk("wrap_drained", 32'(bus.empty), 32'd1);

        // reset mid-drain
        bus.free_ready_by_bank = 4'h0;
        enq(4'b0001, {7'h00, 7'h00, 7'h00, 7'h05});
        cyc();
        idle();
        chk("pre_rst_valid", 32'(bus.free_valid_by_bank), 32'h2);
        RST = 1'b1;
        cyc();
        chk("mid_rst_valid", 32'(bus.free_valid_by_bank), 32'd0);
        chk("mid_rst_empty", 32'(bus.empty), 32'd1);
        chk("mid_rst_enq_ready", 32'(bus.enq_ready), 32'd1);
        RST = 1'b0;

        // PR 0 handling
        bus.free_ready_by_bank = 4'hF;
        enq(4'b0011, {7'h00, 7'h00, 7'h06, 7'h00});
        cyc();
        idle();
`ifdef ROB_PR_FREE_Q_ZERO_FILTER_EN
        chk("zero_valid", 32'(bus.free_valid_by_bank), 32'b0100);
        chk("zero_upper", 32'(bus.free_upper_PR_by_bank), 32'({5'd0, 5'd1, 5'd0, 5'd0}));
        cyc();
        enq(4'b0001, {7'h05, 7'h05, 7'h05, 7'h00});
        cyc();
        idle();
        chk("zero_only_dropped", 32'(bus.empty), 32'd1);
`else
        chk("zero_valid", 32'(bus.free_valid_by_bank), 32'b0101);
        chk("zero_upper", 32'(bus.free_upper_PR_by_bank), 32'({5'd0, 5'd1, 5'd0, 5'd0}));
`endif
        cyc();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bus.enq_valid              = 1'($urandom % 2);
            bus.enq_lane_valid_by_lane = 4'($urandom);
            bus.enq_PR_by_lane         = 28'($urandom);
            bus.free_ready_by_bank     = 4'($urandom);
            cyc();
        end
        idle();
        bus.free_ready_by_bank = 4'hF;
        repeat (12) cyc();
        chk("final_empty", 32'(bus.empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
